// File: rtl/ca2_pkg.sv
// Shared types and helpers for the 2-neighbour ring CA preimage search.
package ca2_pkg;

  localparam int unsigned RULE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  // Rule table index for one cell: left neighbour is the MSB, the cell itself the LSB.
  function automatic logic [1:0] rule_idx(input logic left, input logic self);
    return {left, self};
  endfunction

endpackage

// File: rtl/ca2_step.sv
// Combinational forward CA step on an N-cell ring: y[i] = rule[{a[(i+1)%N], a[i]}].
module ca2_step
  import ca2_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [RULE_W-1:0] rule,
  input  logic [N-1:0]      a,
  output logic [N-1:0]      y
);

  for (genvar i = 0; i < N; i++) begin : g_cell
    // Cell N-1 wraps around to cell 0 as its left neighbour.
    localparam int unsigned LEFT = (i + 1) % N;
    assign y[i] = rule[rule_idx(a[LEFT], a[i])];
  end

endmodule

// File: rtl/ca2_preimage_search.sv
// Exhaustive sequential preimage search for the 2-neighbour ring CA, one candidate per clock.
// Optional CA2_COUNT_ALL_EN: scan every candidate and count all preimages.
module ca2_preimage_search
  import ca2_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [RULE_W-1:0] rule,
  input  logic [N-1:0]      target,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [N-1:0]      preimage,
  output logic [N:0]        count
);

  state_t            state;
  logic [N:0]        cand;
  logic [N:0]        cand_next;
  logic              last;
  logic [RULE_W-1:0] rule_q;
  logic [N-1:0]      target_q;
  logic [N-1:0]      step_y;
  logic              match;

  ca2_step #(.N(N)) u_step (
    .rule (rule_q),
    .a    (cand[N-1:0]),
    .y    (step_y)
  );

  // cand carries an extra bit so the last candidate shows up as a carry out.
  always_comb begin
    cand_next = cand + 1'b1;
    last      = cand_next[N];
    match     = (step_y == target_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      preimage <= '0;
      count    <= '0;
      cand     <= '0;
      rule_q   <= '0;
      target_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= SEARCH;
            busy     <= 1'b1;
            done     <= 1'b0;
            found    <= 1'b0;
            preimage <= '0;
            count    <= '0;
            cand     <= '0;
            rule_q   <= rule;
            target_q <= target;
          end
        end
        SEARCH: begin
          cand <= cand_next;
`ifdef CA2_COUNT_ALL_EN
          if (match) begin
            count <= count + 1'b1;
            if (!found) begin
              found    <= 1'b1;
              preimage <= cand[N-1:0];
            end
          end
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
`else
          // A match on the final candidate still takes the match path.
          if (match) begin
            found    <= 1'b1;
            preimage <= cand[N-1:0];
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
